// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg : constants shared by the fetch stage and its IF/ID register
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_stage_pkg;

  localparam int unsigned NOP_WORD   = 32'h0000_0000;
  localparam int unsigned PC_RESET   = 32'h0000_0000;
  localparam int unsigned PC_STEP    = 32'd4;
  // Low address bits that must be cleared to form a word-aligned fetch address.
  localparam int unsigned ALIGN_MASK = 32'h0000_0003;

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if_id.sv
// ---------------------------------------------------------------------------
// if_id_reg : IF/ID pipeline register with hold (freeze) and bubble (flush)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         flush,
  input  logic [n-1:0] pc_in,
  input  logic [n-1:0] instr_in,
  output logic [n-1:0] pc,
  output logic [n-1:0] instr,
  output logic         valid
);

  logic [n-1:0] r_pc;
  logic [n-1:0] r_instr;
  logic         r_valid;

  // Flush outranks freeze so a taken branch always kills the fetched word.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_pc    <= '0;
      r_instr <= n'(NOP_WORD);
      r_valid <= 1'b0;
    end else if (!freeze) begin
      r_pc    <= pc_in;
      r_instr <= instr_in;
      r_valid <= 1'b1;
    end
  end

  assign pc    = r_pc;
  assign instr = r_instr;
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : PC register, next-PC selection, IF/ID register, fetch counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic         branch_taken,
  input  logic [n-1:0] branch_addr,
  output logic [n-1:0] PC,
  input  logic [n-1:0] instruction,
  output logic [n-1:0] if_id_pc,
  output logic [n-1:0] if_id_instr,
  output logic         if_id_valid,
  output logic [n-1:0] fetch_count
);

  logic [n-1:0] r_pc;
  logic [n-1:0] r_fetch_count;
  logic [n-1:0] w_pc_plus4;
  logic [n-1:0] w_branch_target;
  logic         w_advance;

  assign w_pc_plus4      = r_pc + n'(PC_STEP);
  assign w_branch_target = branch_addr & ~n'(ALIGN_MASK);
  assign w_advance       = !branch_taken && !freeze;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= n'(PC_RESET);
    end else if (branch_taken) begin
      r_pc <= w_branch_target;
    end else if (!freeze) begin
      r_pc <= w_pc_plus4;
    end
  end

  // Counts only words actually delivered into IF/ID; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_advance && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + 1'b1;
    end
  end

  if_id_reg #(
    .n (n)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .flush    (branch_taken),
    .pc_in    (w_pc_plus4),
    .instr_in (instruction),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

  assign PC          = r_pc;
  assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed self-checking bench for fetch_stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  // Narrow instance to reach counter saturation and PC wrap in few cycles.
  logic [3:0]  s_pc;
  logic [3:0]  s_instruction;
  logic [3:0]  s_if_id_pc;
  logic [3:0]  s_if_id_instr;
  logic        s_if_id_valid;
  logic [3:0]  s_fetch_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Instruction memory model: every address returns a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign instruction   = mem_word(pc);
  assign s_instruction = s_pc ^ 4'h5;

  fetch_stage #(.n(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .PC           (pc),
    .instruction  (instruction),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fetch_count  (fetch_count)
  );

  fetch_stage #(.n(4)) dut_small (
    .clk          (clk),
    .rst          (rst),
    .freeze       (1'b0),
    .branch_taken (1'b0),
    .branch_addr  (4'h0),
    .PC           (s_pc),
    .instruction  (s_instruction),
    .if_id_pc     (s_if_id_pc),
    .if_id_instr  (s_if_id_instr),
    .if_id_valid  (s_if_id_valid),
    .fetch_count  (s_fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                           input logic [31:0] e_instr, input logic e_valid, input logic [31:0] e_cnt);
    check({tag, ".pc"},    pc,          e_pc);
    check({tag, ".ifpc"},  if_id_pc,    e_ipc);
    check({tag, ".instr"}, if_id_instr, e_instr);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check({tag, ".count"}, fetch_count, e_cnt);
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    step();
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

    // Three free-running edges from reset
    rst = 1'b0;
    step(); check_all("run1", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1, 32'd1);
    step(); check_all("run2", 32'h8, 32'h8, 32'hC0DE_0004, 1'b1, 32'd2);
    step(); check_all("run3", 32'hC, 32'hC, 32'hC0DE_0008, 1'b1, 32'd3);

    // Freeze two cycles at PC=8
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    check_all("pre_frz", 32'h8, 32'h8, 32'hC0DE_0004, 1'b1, 32'd2);
    freeze = 1'b1;
    step(); check_all("frz1", 32'h8, 32'h8, 32'hC0DE_0004, 1'b1, 32'd2);
    step(); check_all("frz2", 32'h8, 32'h8, 32'hC0DE_0004, 1'b1, 32'd2);
    freeze = 1'b0;
    step(); check_all("unfrz", 32'hC, 32'hC, 32'hC0DE_0008, 1'b1, 32'd3);

    // Advance to PC=0x2C, then take branch to 0xA2 (aligned to 0xA0)
    for (int i = 0; i < 8; i++) step();
    check_all("at2c", 32'h2C, 32'h2C, 32'hC0DE_0028, 1'b1, 32'd11);
    branch_taken = 1'b1; branch_addr = 32'h0000_00A2;
    step(); check_all("br", 32'hA0, 32'h0, 32'h0, 1'b0, 32'd11);
    branch_taken = 1'b0;
    step(); check_all("post_br", 32'hA4, 32'hA4, 32'hC0DE_00A0, 1'b1, 32'd12);

    // Branch and freeze on the same edge
    branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h10;
    step(); check_all("br_frz", 32'h10, 32'h0, 32'h0, 1'b0, 32'd12);
    branch_taken = 1'b0; freeze = 1'b0;
    step(); check_all("post_brfrz", 32'h14, 32'h14, 32'hC0DE_0010, 1'b1, 32'd13);

    // Wrap from 0xFFFFFFFC (target given unaligned)
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFE;
    step(); check_all("br_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd13);
    branch_taken = 1'b0;
    step(); check_all("wrap", 32'h0, 32'h0, 32'h3F21_FFFC, 1'b1, 32'd14);

    // Reset overrides simultaneous branch and freeze
    rst = 1'b1; branch_taken = 1'b1; freeze = 1'b1; branch_addr = 32'h40;
    step(); check_all("rst_ovr", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    rst = 1'b0; branch_taken = 1'b0; freeze = 1'b0;
    step(); check_all("post_rst", 32'h4, 32'h4, 32'hC0DE_0000, 1'b1, 32'd1);

    // Narrow instance: 21 free edges since reset -> count saturates at 15, PC wraps
    for (int i = 0; i < 20; i++) step();
    check("small.count", {28'd0, s_fetch_count}, 32'd15);
    check("small.pc",    {28'd0, s_pc},          32'd4);
    check("small.ifpc",  {28'd0, s_if_id_pc},    32'd4);
    check("small.instr", {28'd0, s_if_id_instr}, 32'h5);
    check("long.count",  fetch_count,            32'd21);
    check("long.pc",     pc,                     32'h54);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter n, default 32, datapath/address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 freeze  input  1  hazard stall from ID; holds PC and IF/ID.
REQ-005 branch_taken  input  1  branch/jump resolved taken in ID this cycle.
REQ-006 branch_addr  input  n  byte target address of taken branch/jump.
REQ-007 PC  output  n  fetch address driven to instruction memory.
REQ-008 instruction  input  n  word returned combinationally by instruction memory for PC.
REQ-009 if_id_pc  output  n  registered PC+4 of the latched instruction.
REQ-010 if_id_instr  output  n  registered instruction for ID.
REQ-011 if_id_valid  output  1  IF/ID holds a real (non-bubble) instruction.
REQ-012 fetch_count  output  n  count of valid instructions delivered into IF/ID.

Function
REQ-013 PC output SHALL be the PC register directly, no combinational path from other inputs.
REQ-014 Next-PC priority SHALL be: rst, then branch_taken, then freeze, then PC+4.
REQ-015 On branch_taken: PC <= {branch_addr[n-1:2], 2'b00}; IF/ID <= bubble (if_id_instr=0, if_id_pc=0, if_id_valid=0), regardless of freeze.
REQ-016 On freeze without branch_taken: PC, if_id_pc, if_id_instr, if_id_valid, fetch_count SHALL hold.
REQ-017 Otherwise: PC <= PC+4; if_id_pc <= PC+4; if_id_instr <= instruction; if_id_valid <= 1.
REQ-018 Latency: instruction at address A SHALL appear on if_id_instr exactly one edge after PC==A with freeze and branch_taken low.
REQ-019 PC+4 SHALL be computed modulo 2^n; 0xFFFFFFFC wraps to 0x00000000 with no flag.
REQ-020 Word 0 SHALL be the NOP encoding; bubbles are indistinguishable from NOP except via if_id_valid.
REQ-021 fetch_count SHALL increment by 1 on each edge executing REQ-017, saturating at 2^n-1.
REQ-022 No address range checking; PC beyond memory depth is passed through unchanged.

Reset
REQ-023 rst high at an edge SHALL set PC=0, if_id_pc=0, if_id_instr=0, if_id_valid=0, fetch_count=0, overriding branch_taken and freeze.
REQ-024 First instruction (address 0) SHALL reach IF/ID on the first edge after rst deasserts.
REQ-025 rst asserted mid-stall or mid-branch SHALL discard the pending action; no state survives.

Structure
REQ-026 Shared package holds: NOP word (0), PC_RESET (0), PC_STEP (4), address alignment mask.
REQ-027 IF/ID register SHALL be sub-module if_id_reg (ports clk, rst, freeze, flush, pc_in, instr_in, pc, instr, valid); fetch_stage holds PC register, adder, next-PC mux, counter.

Verification
REQ-028 Reset then 3 free-running edges with memory words W0..W2 -> PC=0,4,8,12; if_id_instr=W0,W1,W2; if_id_pc=4,8,12; fetch_count=3.
REQ-029 freeze high 2 cycles at PC=8 -> PC stays 8, IF/ID and fetch_count unchanged; release -> PC=12 next edge.
REQ-030 branch_taken=1, branch_addr=0x000000A2 at PC=0x2C -> PC=0xA0, if_id_valid=0, if_id_instr=0, fetch_count unchanged.
REQ-031 branch_taken=1 and freeze=1 same edge, branch_addr=0x10 -> PC=0x10, bubble latched.
REQ-032 Force PC to 0xFFFFFFFC via branch, one free edge -> PC=0x00000000, if_id_pc=0.
REQ-033 rst asserted with branch_taken=1 and freeze=1 -> all outputs 0 after that edge; next free edge PC=4, fetch_count=1.
